stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 135 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Control block for a stopwatch: two raw buttons are synchronised and
//   debounced. Their rising edges drive an IDLE/RUN/STOP state machine. A
//   prescaler produces the count-enable strobe for the digit chain.
//
// Ports
//   clk_i             system clock (CLK_HZ)
//   res_i             synchronous active-high reset
//   btn_start_stop_i  raw async start/stop button, high = pressed
//   btn_clear_i       raw async clear button, high = pressed
//   tick_en_o         one-cycle count enable, period PRESCALE while running
//   cnt_res_o         clear for the downstream digit counters (high in IDLE)
//   running_o         high while in RUN
//   state_o           IDLE=0, RUN=1, STOP=2
//
// Build option
//   STOPWATCH_CTRL_RESUME_PHASE_CLEAR_EN  when defined, the prescaler restarts
//   from 0 on STOP->RUN. When undefined, a resume continues the interrupted
//   tick phase.
module stopwatch_ctrl #(
  parameter int CLK_HZ          = 1000,
  parameter int TICK_HZ         = 100,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       res_i,
  input  logic       btn_start_stop_i,
  input  logic       btn_clear_i,
  output logic       tick_en_o,
  output logic       cnt_res_o,
  output logic       running_o,
  output logic [1:0] state_o
);

  localparam int PRESCALE = CLK_HZ / TICK_HZ;
  localparam int PW       = $clog2(PRESCALE);
  localparam int DW       = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;

  // button index inside the packed vectors
  localparam int B_SS  = 0;
  localparam int B_CLR = 1;

  if ((CLK_HZ % TICK_HZ) != 0 || PRESCALE < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("stopwatch_ctrl: CLK_HZ must be a multiple of TICK_HZ, PRESCALE >= 2, DEBOUNCE_CYCLES >= 1");
  end

  logic [1:0]         btn_raw;
  logic [1:0]         sync1_q, sync1_d;
  logic [1:0]         sync2_q, sync2_d;
  logic [1:0]         lvl_q, lvl_d;
  logic [1:0][DW-1:0] dcnt_q, dcnt_d;
  logic [1:0]         press;
  logic [1:0]         state_q, state_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic               presc_top;

  assign btn_raw = {btn_clear_i, btn_start_stop_i};

  // Synchroniser + debounce. The counter tracks how many consecutive samples
  // have disagreed with the accepted level. A matching sample restarts it.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    lvl_d   = lvl_q;
    dcnt_d  = dcnt_q;
    for (int b = 0; b < 2; b++) begin
      if (sync2_q[b] == lvl_q[b]) begin
        dcnt_d[b] = '0;
      end else if (dcnt_q[b] == DW'(DEBOUNCE_CYCLES - 1)) begin
        lvl_d[b]  = sync2_q[b];
        dcnt_d[b] = '0;
      end else begin
        dcnt_d[b] = dcnt_q[b] + DW'(1);
      end
    end
    // Rising edge of the accepted level. It is seen by the FSM on the same
    // edge that loads the new level, so a held button yields exactly one event.
    press = lvl_d & ~lvl_q;
  end

  // Clear beats start/stop outside RUN. In RUN, clear is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!press[B_CLR] && press[B_SS]) state_d = S_RUN;
      S_RUN:   if (press[B_SS]) state_d = S_STOP;
      S_STOP:  if (press[B_CLR]) state_d = S_IDLE;
               else if (press[B_SS]) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  assign presc_top = (presc_q == PW'(PRESCALE - 1));

  always_comb begin
    presc_d = presc_q;
    case (state_q)
      S_RUN:   presc_d = presc_top ? '0 : presc_q + PW'(1);
      S_STOP: begin
`ifdef STOPWATCH_CTRL_RESUME_PHASE_CLEAR_EN
        if (state_d == S_RUN) presc_d = '0;
`endif
      end
      default: presc_d = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      dcnt_q  <= '0;
      state_q <= S_IDLE;
      presc_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      lvl_q   <= lvl_d;
      dcnt_q  <= dcnt_d;
      state_q <= state_d;
      presc_q <= presc_d;
    end
  end

  assign tick_en_o = (state_q == S_RUN) && presc_top;
  assign cnt_res_o = (state_q == S_IDLE);
  assign running_o = (state_q == S_RUN);
  assign state_o   = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
//   Drives stopwatch_ctrl with directed and random button activity. Each
//   cycle's outputs are compared against a cycle-level reference model of
//   the button/state behaviour.
module tb_stopwatch_ctrl;
  localparam int CLK_HZ = 1000;
  localparam int TICK_HZ = 100;
  localparam int DB = 4;
  localparam int PRE = CLK_HZ / TICK_HZ;

  logic clk = 1'b0;
  logic res_i = 1'b1;
  logic btn_start_stop_i = 1'b0;
  logic btn_clear_i = 1'b0;
  logic tick_en_o, cnt_res_o, running_o;
  logic [1:0] state_o;

  stopwatch_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DEBOUNCE_CYCLES(DB)) dut (
    .clk_i(clk), .res_i(res_i),
    .btn_start_stop_i(btn_start_stop_i), .btn_clear_i(btn_clear_i),
    .tick_en_o(tick_en_o), .cnt_res_o(cnt_res_o),
    .running_o(running_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  // Reference model: state 0/1/2 = IDLE/RUN/STOP. m_cnt counts cycles spent
  // in RUN since the counting phase was last restarted. Each button level is
  // delayed two cycles; the debounced level flips once the last DB delayed
  // samples all disagree with it.
  int         m_state, m_cnt;
  bit         m_lvl [2];
  bit         m_d1 [2];
  bit         m_d2 [2];
  logic [31:0] m_hist [2];

  logic [4:0] obs, exp_v;   // {state, tick, cnt_res, running}

  function automatic void model_reset();
    m_state = 0;
    m_cnt = 0;
    for (int b = 0; b < 2; b++) begin
      m_lvl[b] = 0; m_d1[b] = 0; m_d2[b] = 0; m_hist[b] = '0;
    end
  endfunction

  // Drive one cycle, record observed/expected outputs for that cycle, advance model.
  task automatic step(input bit ss, input bit clr, input bit rst);
    bit raw [2];
    bit pr [2];
    bit s, all_diff;
    int ns;
    btn_start_stop_i = ss;
    btn_clear_i = clr;
    res_i = rst;
    @(negedge clk);
    obs = {state_o, tick_en_o, cnt_res_o, running_o};
    exp_v = {2'(m_state), (m_state == 1) && (m_cnt % PRE == PRE - 1), m_state == 0, m_state == 1};
    if (rst) begin
      model_reset();
    end else begin
      raw[0] = ss;
      raw[1] = clr;
      for (int b = 0; b < 2; b++) begin
        s = m_d2[b];
        m_d2[b] = m_d1[b];
        m_d1[b] = raw[b];
        m_hist[b] = {m_hist[b][30:0], s};
        all_diff = 1;
        for (int k = 0; k < DB; k++) if (m_hist[b][k] == m_lvl[b]) all_diff = 0;
        pr[b] = all_diff && !m_lvl[b];
        if (all_diff) m_lvl[b] = !m_lvl[b];
      end
      ns = m_state;
      case (m_state)
        0: if (pr[1]) ns = 0; else if (pr[0]) ns = 1;
        1: if (pr[0]) ns = 2;
        default: if (pr[1]) ns = 0; else if (pr[0]) ns = 1;
      endcase
      if (m_state == 1) m_cnt++;
      else if (m_state == 0) m_cnt = 0;
`ifdef STOPWATCH_CTRL_RESUME_PHASE_CLEAR_EN
      if (m_state == 2 && ns == 1) m_cnt = 0;
`endif
      m_state = ns;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    step(0, 0, 1);
    checks++; if (obs !== exp_v) $display("FAIL rst_cycle cyc=%0d got=%b want=%b", cyc, obs, exp_v); else passed++;
    step(0, 0, 0);
    checks++; if (obs !== 5'b00_0_1_0) $display("FAIL rst_outputs got=%b want=%b", obs, 5'b00_0_1_0); else passed++;
    // clear in IDLE stays in IDLE
    for (int i = 0; i < 16; i++) begin
      step(0, i < 8, 0);
      checks++; if (obs !== exp_v) $display("FAIL idle_clear cyc=%0d got=%b want=%b", cyc, obs, exp_v); else passed++;
    end
    checks++; if (obs !== 5'b00_0_1_0) $display("FAIL idle_clear_end got=%b want=%b", obs, 5'b00_0_1_0); else passed++;
  endtask

  task automatic test_start_hold();
    int first_run = -1, first_tick = -1, nt = 0;
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 0);
      checks++; if (obs !== exp_v) $display("FAIL hold cyc=%0d got=%b want=%b", cyc, obs, exp_v); else passed++;
      if (first_run < 0 && obs[4:3] == 2'd1) first_run = i;
      if (obs[2]) begin
        if (first_tick < 0) first_tick = i;
        nt++;
      end
    end
    checks++; if (first_run != 6) $display("FAIL start_latency got=%0d want=%0d", first_run, 6); else passed++;
    checks++; if (first_tick != 15) $display("FAIL first_tick got=%0d want=%0d", first_tick, 15); else passed++;
    checks++; if (nt != 3) $display("FAIL tick_count got=%0d want=%0d", nt, 3); else passed++;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0);
      checks++; if (obs !== exp_v) $display("FAIL hold_release cyc=%0d got=%b want=%b", cyc, obs, exp_v); else passed++;
    end
    checks++; if (obs[4:3] !== 2'd1) $display("FAIL single_event got=%0d want=%0d", obs[4:3], 1); else passed++;
  endtask

  task automatic test_bounce();
    logic [1:0] prev = 2'd1;
    int nchg = 0, chg_i = -1;
    for (int i = 0; i < 32; i++) begin
      step((i < 20) ? ((i / 2) % 2 == 0) : 1'b1, 0, 0);
      checks++; if (obs !== exp_v) $display("FAIL bounce cyc=%0d got=%b want=%b", cyc, obs, exp_v); else passed++;
      if (obs[4:3] != prev) begin
        nchg++;
        chg_i = i;
        prev = obs[4:3];
      end
    end
    checks++; if (nchg != 1) $display("FAIL bounce_events got=%0d want=%0d", nchg, 1); else passed++;
    checks++; if (chg_i != 26) $display("FAIL bounce_latency got=%0d want=%0d", chg_i, 26); else passed++;
    checks++; if (prev !== 2'd2) $display("FAIL bounce_state got=%0d want=%0d", prev, 2); else passed++;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0);
      checks++; if (obs !== exp_v) $display("FAIL bounce_release cyc=%0d got=%b want=%b", cyc, obs, exp_v); else passed++;
    end
  endtask

  task automatic test_clear();
    // phases from STOP: clear->IDLE, ss->RUN, clear ignored, ss->STOP, both->IDLE
    int ph_ss [5]  = '{0, 1, 0, 1, 1};
    int ph_clr [5] = '{1, 0, 1, 0, 1};
    int ph_st [5]  = '{0, 1, 1, 2, 0};
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 16; i++) begin
        step(i < 8 && ph_ss[p] != 0, i < 8 && ph_clr[p] != 0, 0);
        checks++; if (obs !== exp_v) $display("FAIL clear_ph%0d cyc=%0d got=%b want=%b", p, cyc, obs, exp_v); else passed++;
      end
      checks++; if (obs[4:3] !== 2'(ph_st[p])) $display("FAIL clear_state_ph%0d got=%0d want=%0d", p, obs[4:3], ph_st[p]); else passed++;
      checks++; if (obs[1] !== (ph_st[p] == 0)) $display("FAIL clear_cnt_res_ph%0d got=%b want=%b", p, obs[1], ph_st[p] == 0); else passed++;
    end
  endtask

  task automatic test_stop_resume();
    int stop_i = -1, nt_run = 0, nt_stop = 0, res_tick = -1, want;
    for (int i = 0; i < 80; i++) begin
      step((i < 10) || (i >= 36 && i < 44), 0, 0);
      checks++; if (obs !== exp_v) $display("FAIL stop cyc=%0d got=%b want=%b", cyc, obs, exp_v); else passed++;
      if (stop_i < 0 && obs[4:3] == 2'd2) stop_i = i;
      if (obs[2]) begin
        if (stop_i < 0) nt_run++; else nt_stop++;
      end
    end
    checks++; if (stop_i != 42) $display("FAIL stop_at got=%0d want=%0d", stop_i, 42); else passed++;
    checks++; if (nt_run != 3) $display("FAIL ticks_before_stop got=%0d want=%0d", nt_run, 3); else passed++;
    checks++; if (nt_stop != 0) $display("FAIL ticks_in_stop got=%0d want=%0d", nt_stop, 0); else passed++;
    for (int j = 0; j < 30; j++) begin
      step(j < 8, 0, 0);
      checks++; if (obs !== exp_v) $display("FAIL resume cyc=%0d got=%b want=%b", cyc, obs, exp_v); else passed++;
      if (res_tick < 0 && obs[2]) res_tick = j;
    end
`ifdef STOPWATCH_CTRL_RESUME_PHASE_CLEAR_EN
    want = 6 + 9;
`else
    want = 6 + 3;
`endif
    checks++; if (res_tick != want) $display("FAIL resume_tick got=%0d want=%0d", res_tick, want); else passed++;
    checks++; if (obs[4:3] !== 2'd1) $display("FAIL resume_state got=%0d want=%0d", obs[4:3], 1); else passed++;
  endtask

  task automatic test_reset_mid_run();
    int n = 0, first_run = -1;
    while (!(m_state == 1 && m_cnt % PRE == PRE - 1) && n < 2 * PRE) begin
      step(0, 0, 0);
      checks++; if (obs !== exp_v) $display("FAIL seek_tick cyc=%0d got=%b want=%b", cyc, obs, exp_v); else passed++;
      n++;
    end
    checks++; if (n >= 2 * PRE) $display("FAIL seek_tick_timeout got=%0d want<%0d", n, 2 * PRE); else passed++;
    step(0, 0, 1);
    checks++; if (obs !== exp_v) $display("FAIL rst_at_tick cyc=%0d got=%b want=%b", cyc, obs, exp_v); else passed++;
    step(0, 0, 0);
    checks++; if (obs !== 5'b00_0_1_0) $display("FAIL after_mid_rst got=%b want=%b", obs, 5'b00_0_1_0); else passed++;
    // button held through reset
    step(1, 0, 1);
    step(1, 0, 1);
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0);
      checks++; if (obs !== exp_v) $display("FAIL held_rst cyc=%0d got=%b want=%b", cyc, obs, exp_v); else passed++;
      if (first_run < 0 && obs[4:3] == 2'd1) first_run = i;
    end
    checks++; if (first_run != 6) $display("FAIL held_rst_latency got=%0d want=%0d", first_run, 6); else passed++;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0);
      checks++; if (obs !== exp_v) $display("FAIL held_rel cyc=%0d got=%b want=%b", cyc, obs, exp_v); else passed++;
    end
  endtask

  task automatic test_random();
    bit ss = 0, clr = 0, rst;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) ss = !ss;
      if ($urandom_range(0, 11) == 0) clr = !clr;
      rst = ($urandom_range(0, 299) == 0);
      step(ss, clr, rst);
      checks++; if (obs !== exp_v) $display("FAIL random cyc=%0d got=%b want=%b", cyc, obs, exp_v); else passed++;
    end
  endtask

  initial begin
    res_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    test_reset();
    test_start_hold();
    test_bounce();
    test_clear();
    test_stop_resume();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
